// File: rtl/cnn_pool_pkg.sv
// Shared definitions for the conv-output to max-pooling window feeder.
package cnn_pool_pkg;

   localparam int unsigned DATA_W = 22;

   typedef enum logic [1:0] {
      StIdle,
      StEvenRow,
      StOddRow,
      StDone
   } pool_state_t;

   function automatic int unsigned win_count(input int unsigned w, input int unsigned h);
      return (w / 2) * (h / 2);
   endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// One feature-map row of storage: a single write port and two combinational read ports.
module pool_line_buffer #(
   parameter int unsigned DATA_W = 22,
   parameter int unsigned IMG_W  = 126,
   parameter int unsigned AW     = $clog2(IMG_W)
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic [AW-1:0]     i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [AW-1:0]     i_raddr_a,
   input  logic [AW-1:0]     i_raddr_b,
   output logic [DATA_W-1:0] o_rdata_a,
   output logic [DATA_W-1:0] o_rdata_b
);

   // Every entry is rewritten by the even row before the odd row reads it, so no reset.
   logic [DATA_W-1:0] r_mem [IMG_W];

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata_a = r_mem[i_raddr_a];
   assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/pool_window_feeder.sv
// Turns a row-major pixel stream into non-overlapping 2x2 windows for the max-pooling unit.
// The even row is parked in a line buffer; the odd row pairs with it as it arrives.
module pool_window_feeder #(
   parameter int unsigned DATA_W = cnn_pool_pkg::DATA_W,
   parameter int unsigned IMG_W  = 126,
   parameter int unsigned IMG_H  = 126
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [DATA_W-1:0] pixel_in,
   input  logic              pixel_vld,
   output logic [DATA_W-1:0] win_tl,
   output logic [DATA_W-1:0] win_tr,
   output logic [DATA_W-1:0] win_bl,
   output logic [DATA_W-1:0] win_br,
   output logic              win_vld,
   output logic              busy,
   output logic              frame_done
);

   import cnn_pool_pkg::*;

   localparam int unsigned CW = $clog2(IMG_W);
   localparam int unsigned RW = $clog2(IMG_H);

   pool_state_t       r_state;
   logic [CW-1:0]     r_col;
   logic [RW-1:0]     r_row;
   logic [DATA_W-1:0] r_held_bl;
   logic [DATA_W-1:0] r_tl;
   logic [DATA_W-1:0] r_tr;
   logic [DATA_W-1:0] r_bl;
   logic [DATA_W-1:0] r_br;
   logic              r_win_vld;
   logic              r_busy;
   logic              r_frame_done;

   logic              w_col_last;
   logic              w_row_last;
   logic              w_buf_we;
   logic [CW-1:0]     w_col_left;
   logic [DATA_W-1:0] w_buf_left;
   logic [DATA_W-1:0] w_buf_right;

   assign w_col_last = (r_col == CW'(IMG_W - 1));
   assign w_row_last = (r_row == RW'(IMG_H - 1));
   assign w_buf_we   = (r_state == StEvenRow) && pixel_vld;
   // Windows only fire at odd columns, where clearing bit 0 yields col-1.
   assign w_col_left = r_col & ~CW'(1);

   pool_line_buffer #(
      .DATA_W (DATA_W),
      .IMG_W  (IMG_W),
      .AW     (CW)
   ) u_line_buf (
      .clk       (clk),
      .i_we      (w_buf_we),
      .i_waddr   (r_col),
      .i_wdata   (pixel_in),
      .i_raddr_a (w_col_left),
      .i_raddr_b (r_col),
      .o_rdata_a (w_buf_left),
      .o_rdata_b (w_buf_right)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= StIdle;
         r_col        <= '0;
         r_row        <= '0;
         r_held_bl    <= '0;
         r_tl         <= '0;
         r_tr         <= '0;
         r_bl         <= '0;
         r_br         <= '0;
         r_win_vld    <= 1'b0;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_win_vld    <= 1'b0;
         r_frame_done <= 1'b0;
         unique case (r_state)
            StIdle: begin
               if (start) begin
                  r_state <= StEvenRow;
                  r_busy  <= 1'b1;
               end
            end
            StEvenRow: begin
               if (pixel_vld) begin
                  if (!w_col_last) begin
                     r_col <= r_col + CW'(1);
                  end else begin
                     r_col <= '0;
                     // An odd frame height ends on an even-row fill.
                     if (w_row_last) begin
                        r_row        <= '0;
                        r_state      <= StDone;
                        r_busy       <= 1'b0;
                        r_frame_done <= 1'b1;
                     end else begin
                        r_row   <= r_row + RW'(1);
                        r_state <= StOddRow;
                     end
                  end
               end
            end
            StOddRow: begin
               if (pixel_vld) begin
                  if (r_col[0]) begin
                     r_tl      <= w_buf_left;
                     r_tr      <= w_buf_right;
                     r_bl      <= r_held_bl;
                     r_br      <= pixel_in;
                     r_win_vld <= 1'b1;
                  end else begin
                     r_held_bl <= pixel_in;
                  end
                  if (!w_col_last) begin
                     r_col <= r_col + CW'(1);
                  end else begin
                     r_col <= '0;
                     if (w_row_last) begin
                        r_row        <= '0;
                        r_state      <= StDone;
                        r_busy       <= 1'b0;
                        r_frame_done <= 1'b1;
                     end else begin
                        r_row   <= r_row + RW'(1);
                        r_state <= StEvenRow;
                     end
                  end
               end
            end
            StDone: begin
               r_state <= StIdle;
            end
            default: begin
               r_state <= StIdle;
            end
         endcase
      end
   end

   assign win_tl     = r_tl;
   assign win_tr     = r_tr;
   assign win_bl     = r_bl;
   assign win_br     = r_br;
   assign win_vld    = r_win_vld;
   assign busy       = r_busy;
   assign frame_done = r_frame_done;

endmodule

// File: tb/tb_pool_window_feeder.sv
// Bench for pool_window_feeder: a 4x4 and a 5x5 instance checked against a pixel-index model.
module tb_pool_window_feeder;

   import cnn_pool_pkg::*;

   localparam int DW = 22;

   logic          clk = 1'b0;
   logic          reset;
   logic          start4;
   logic          start5;
   logic          pixel_vld;
   logic [DW-1:0] pixel_in;

   logic [DW-1:0] tl4, tr4, bl4, br4, tl5, tr5, bl5, br5;
   logic          vld4, busy4, done4, vld5, busy5, done5;

   always #5 clk = ~clk;

   pool_window_feeder #(.DATA_W(DW), .IMG_W(4), .IMG_H(4)) u_dut4 (
      .clk        (clk),
      .reset      (reset),
      .start      (start4),
      .pixel_in   (pixel_in),
      .pixel_vld  (pixel_vld),
      .win_tl     (tl4),
      .win_tr     (tr4),
      .win_bl     (bl4),
      .win_br     (br4),
      .win_vld    (vld4),
      .busy       (busy4),
      .frame_done (done4)
   );

   pool_window_feeder #(.DATA_W(DW), .IMG_W(5), .IMG_H(5)) u_dut5 (
      .clk        (clk),
      .reset      (reset),
      .start      (start5),
      .pixel_in   (pixel_in),
      .pixel_vld  (pixel_vld),
      .win_tl     (tl5),
      .win_tr     (tr5),
      .win_bl     (bl5),
      .win_br     (br5),
      .win_vld    (vld5),
      .busy       (busy5),
      .frame_done (done5)
   );

   // Model: tracks the accepted-pixel index k; a window closes at odd row and odd column.
   logic [DW-1:0] m_tl [2];
   logic [DW-1:0] m_tr [2];
   logic [DW-1:0] m_bl [2];
   logic [DW-1:0] m_br [2];
   logic          m_vld [2];
   logic          m_done [2];
   logic          m_busy [2];
   int            m_k [2];
   logic [DW-1:0] m_frame [2][32];

   task automatic model_step(input int d, input int w, input int h, input logic st);
      int   k, r, c;
      logic was_done;
      was_done  = m_done[d];
      m_vld[d]  = 1'b0;
      m_done[d] = 1'b0;
      if (m_busy[d]) begin
         if (pixel_vld) begin
            k = m_k[d];
            m_frame[d][k] = pixel_in;
            r = k / w;
            c = k % w;
            if ((r % 2 == 1) && (c % 2 == 1)) begin
               m_tl[d]  = m_frame[d][k - w - 1];
               m_tr[d]  = m_frame[d][k - w];
               m_bl[d]  = m_frame[d][k - 1];
               m_br[d]  = pixel_in;
               m_vld[d] = 1'b1;
            end
            if (k == w * h - 1) begin
               m_busy[d] = 1'b0;
               m_done[d] = 1'b1;
               m_k[d]    = 0;
            end else begin
               m_k[d] = k + 1;
            end
         end
      end else if (st && !was_done) begin
         m_busy[d] = 1'b1;
      end
   endtask

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int d = 0; d < 2; d++) begin
            m_tl[d] = '0; m_tr[d] = '0; m_bl[d] = '0; m_br[d] = '0;
            m_vld[d] = 1'b0; m_done[d] = 1'b0; m_busy[d] = 1'b0; m_k[d] = 0;
         end
      end else begin
         model_step(0, 4, 4, start4);
         model_step(1, 5, 5, start5);
      end
   end

   int            n_err = 0;
   int            n_chk = 0;
   int            cyc_n = 0;
   int            t_start = 0;
   logic [87:0]   q4 [$];
   logic [87:0]   q5 [$];
   int            qc4 [$];
   int            n_done4, n_done5, done_t5;
   logic          done_vld4;
   logic [DW-1:0] pix [32];

   task automatic chk(input string name, input logic [87:0] act, input logic [87:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic cmp(input int d, input logic [DW-1:0] tl, input logic [DW-1:0] tr,
                      input logic [DW-1:0] bl, input logic [DW-1:0] br,
                      input logic vld, input logic bsy, input logic dn);
      string p;
      p = (d == 0) ? "w4" : "w5";
      chk({p, ".win_tl"}, 88'(tl), 88'(m_tl[d]));
      chk({p, ".win_tr"}, 88'(tr), 88'(m_tr[d]));
      chk({p, ".win_bl"}, 88'(bl), 88'(m_bl[d]));
      chk({p, ".win_br"}, 88'(br), 88'(m_br[d]));
      chk({p, ".win_vld"}, 88'(vld), 88'(m_vld[d]));
      chk({p, ".busy"}, 88'(bsy), 88'(m_busy[d]));
      chk({p, ".frame_done"}, 88'(dn), 88'(m_done[d]));
   endtask

   // One clock: sample 3 units after the rising edge, compare, capture, return on falling edge.
   task automatic cyc();
      @(posedge clk);
      #3;
      cyc_n++;
      cmp(0, tl4, tr4, bl4, br4, vld4, busy4, done4);
      cmp(1, tl5, tr5, bl5, br5, vld5, busy5, done5);
      if (vld4) begin
         q4.push_back({tl4, tr4, bl4, br4});
         qc4.push_back(cyc_n - t_start);
      end
      if (done4) begin
         n_done4++;
         done_vld4 = vld4;
      end
      if (vld5) q5.push_back({tl5, tr5, bl5, br5});
      if (done5) begin
         n_done5++;
         done_t5 = cyc_n - t_start;
      end
      @(negedge clk);
   endtask

   task automatic clear_capture();
      q4.delete(); q5.delete(); qc4.delete();
      n_done4 = 0; n_done5 = 0; done_t5 = -1; done_vld4 = 1'b0;
   endtask

   task automatic run_frame(input int d, input int n, input bit gap, input bit noise);
      clear_capture();
      if (noise) begin
         pixel_vld = 1'b1;
         pixel_in  = 22'h155555;
         repeat (3) cyc();
      end
      pixel_vld = 1'b0;
      start4 = (d == 0);
      start5 = (d == 1);
      cyc();
      t_start = cyc_n;
      start4 = 1'b0;
      start5 = 1'b0;
      for (int i = 0; i < n; i++) begin
         pixel_in  = pix[i];
         pixel_vld = 1'b1;
         if (noise && i == 7) begin
            start4 = (d == 0);
            start5 = (d == 1);
         end
         cyc();
         start4 = 1'b0;
         start5 = 1'b0;
         if (gap) begin
            pixel_vld = 1'b0;
            pixel_in  = 22'h2AAAAA;
            cyc();
         end
      end
      pixel_vld = 1'b0;
      repeat (3) cyc();
   endtask

   task automatic chk_win(input string name, input int d, input int i,
                          input int a, input int b, input int c, input int e);
      logic [87:0] got;
      got = '1;
      if (d == 0 && i < q4.size()) got = q4[i];
      if (d == 1 && i < q5.size()) got = q5[i];
      chk(name, got, {DW'(a), DW'(b), DW'(c), DW'(e)});
   endtask

   task automatic chk_t4(input string name, input int i, input int exp);
      int got;
      got = (i < qc4.size()) ? qc4[i] : -1;
      chk(name, 88'(got), 88'(exp));
   endtask

   task automatic chk_frame1(input string tag);
      chk_win({tag, " win0"}, 0, 0, 0, 1, 4, 5);
      chk_win({tag, " win1"}, 0, 1, 2, 3, 6, 7);
      chk_win({tag, " win2"}, 0, 2, 8, 9, 12, 13);
      chk_win({tag, " win3"}, 0, 3, 10, 11, 14, 15);
      chk({tag, " count"}, 88'(q4.size()), 88'(win_count(4, 4)));
      chk({tag, " done count"}, 88'(n_done4), 88'(1));
   endtask

   initial begin
      logic signed [DW-1:0] mx;
      reset = 1'b1; start4 = 1'b0; start5 = 1'b0; pixel_vld = 1'b0; pixel_in = '0;
      clear_capture();
      repeat (2) cyc();
      chk("reset busy", 88'(busy4), 88'(0));
      chk("reset win_vld", 88'(vld4), 88'(0));
      chk("reset win_br", 88'(br5), 88'(0));
      reset = 1'b0;
      cyc();

      // Contiguous 4x4 frame.
      for (int i = 0; i < 32; i++) pix[i] = DW'(i);
      run_frame(0, 16, 1'b0, 1'b0);
      chk_frame1("t1");
      chk_t4("t1 time0", 0, 6);
      chk_t4("t1 time1", 1, 8);
      chk_t4("t1 time2", 2, 14);
      chk_t4("t1 time3", 3, 16);
      chk("t1 done with last win", 88'(done_vld4), 88'(1));
      chk("t1 busy after", 88'(busy4), 88'(0));

      // Same frame with a gap after every pixel.
      run_frame(0, 16, 1'b1, 1'b0);
      chk_frame1("t2");
      chk_t4("t2 time0", 0, 11);
      chk_t4("t2 time3", 3, 31);

      // 5x5 frame: last column and last row are dropped.
      run_frame(1, 25, 1'b0, 1'b0);
      chk_win("t3 win0", 1, 0, 0, 1, 5, 6);
      chk_win("t3 win1", 1, 1, 2, 3, 7, 8);
      chk_win("t3 win2", 1, 2, 10, 11, 15, 16);
      chk_win("t3 win3", 1, 3, 12, 13, 17, 18);
      chk("t3 count", 88'(q5.size()), 88'(win_count(5, 5)));
      chk("t3 done count", 88'(n_done5), 88'(1));
      chk("t3 done time", 88'(done_t5), 88'(25));

      // Signed extremes pass bit-exact.
      for (int i = 0; i < 32; i++) pix[i] = '0;
      pix[0] = 22'h3FFFFF; pix[1] = 22'h200000; pix[4] = 22'h1FFFFF; pix[5] = 22'h000005;
      run_frame(0, 16, 1'b0, 1'b0);
      chk_win("t4 signed win", 0, 0, 'h3FFFFF, 'h200000, 'h1FFFFF, 'h5);
      mx = 22'sh200000;
      if (q4.size() > 0) begin
         for (int j = 0; j < 4; j++) begin
            if ($signed(q4[0][j*DW +: DW]) > mx) mx = $signed(q4[0][j*DW +: DW]);
         end
      end
      chk("t4 pool max", 88'(mx), 88'(22'h1FFFFF));

      // Reset after pixel 6 of a frame.
      for (int i = 0; i < 32; i++) pix[i] = DW'(i);
      clear_capture();
      start4 = 1'b1;
      cyc();
      start4 = 1'b0;
      for (int i = 0; i < 7; i++) begin
         pixel_in  = pix[i];
         pixel_vld = 1'b1;
         cyc();
      end
      pixel_vld = 1'b0;
      reset = 1'b1;
      #1;
      chk("t5 tl", 88'(tl4), 88'(0));
      chk("t5 tr", 88'(tr4), 88'(0));
      chk("t5 bl", 88'(bl4), 88'(0));
      chk("t5 br", 88'(br4), 88'(0));
      chk("t5 vld", 88'(vld4), 88'(0));
      chk("t5 busy", 88'(busy4), 88'(0));
      chk("t5 done", 88'(done4), 88'(0));
      @(negedge clk);
      cyc();
      reset = 1'b0;
      pixel_vld = 1'b1;
      repeat (4) cyc();
      pixel_vld = 1'b0;
      chk("t5 aborted wins", 88'(q4.size()), 88'(1));
      chk("t5 aborted done", 88'(n_done4), 88'(0));
      run_frame(0, 16, 1'b0, 1'b0);
      chk_frame1("t5 rerun");

      // Pixels while idle and a second start mid-frame change nothing.
      run_frame(0, 16, 1'b0, 1'b1);
      chk_frame1("t6");
      chk_t4("t6 time0", 0, 6);
      chk_t4("t6 time3", 3, 16);
      chk("t6 done with last win", 88'(done_vld4), 88'(1));

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
